// File: rtl/e203_exu_wbck_arbt_pkg.sv
// Shared widths, defaults and helpers for the EXU writeback arbiter.
// Also holds the starvation-limit default used by the arbiter.
package e203_exu_wbck_arbt_pkg;

    localparam int E203_XLEN            = 32;
    localparam int E203_RFIDX_WIDTH     = 5;
    localparam int E203_RFREG_NUM       = 32;
    localparam int E203_WBCK_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_LONGP
    } wbck_gnt_e;

    // Starvation counter is at least 3 bits wide, wider if the limit needs it.
    function automatic int starve_cnt_w(input int smax);
        int w;
        w = $clog2(smax + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/e203_exu_wbck_sb.sv
// Pending-write scoreboard for long-pipe destinations; flags regs whose write is outstanding.
module e203_exu_wbck_sb
    import e203_exu_wbck_arbt_pkg::*;
#(
    parameter int RFIDX_W   = E203_RFIDX_WIDTH,
    parameter int RFREG_NUM = E203_RFREG_NUM
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_vld,
    input  logic [RFIDX_W-1:0] set_idx,
    input  logic               clr_vld,
    input  logic [RFIDX_W-1:0] clr_idx,
    input  logic [RFIDX_W-1:0] chk_src1_idx,
    input  logic [RFIDX_W-1:0] chk_src2_idx,
    input  logic [RFIDX_W-1:0] chk_dest_idx,
    output logic               chk_src1_hzd,
    output logic               chk_src2_hzd,
    output logic               chk_dest_hzd
);

    logic [RFREG_NUM-1:0] pend_r;
    logic [RFREG_NUM-1:0] pend_nxt;
    logic [RFREG_NUM-1:0] set_mask;
    logic [RFREG_NUM-1:0] clr_mask;

    // Set is applied after clear so a same-cycle reissue of the index stays pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_vld) set_mask[set_idx] = 1'b1;
        if (clr_vld) clr_mask[clr_idx] = 1'b1;
        pend_nxt    = (pend_r & ~clr_mask) | set_mask;
        pend_nxt[0] = 1'b0;
    end

    sirv_gnrl_dfflr #(.DW(RFREG_NUM)) u_pend_dff (
        .lden  (set_vld | clr_vld),
        .dnxt  (pend_nxt),
        .qout  (pend_r),
        .clk   (clk),
        .rst_n (rst_n)
    );

    assign chk_src1_hzd = pend_r[chk_src1_idx];
    assign chk_src2_hzd = pend_r[chk_src2_idx];
    assign chk_dest_hzd = pend_r[chk_dest_idx];

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// General-purpose load-enable flop with asynchronous active-low reset to zero.
module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst_n
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/e203_exu_wbck_arbt.sv
// Writeback arbiter: long-pipe has fixed priority, a starvation counter forces ALU grants.
// Optional long-pipe pending-write scoreboard enabled by E203_WBCK_LONGP_SB_EN.
module e203_exu_wbck_arbt
    import e203_exu_wbck_arbt_pkg::*;
#(
    parameter int XLEN       = E203_XLEN,
    parameter int RFIDX_W    = E203_RFIDX_WIDTH,
    parameter int RFREG_NUM  = E203_RFREG_NUM,
    parameter int STARVE_MAX = E203_WBCK_STARVE_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_wbck_valid,
    output logic               alu_wbck_ready,
    input  logic               alu_wbck_rdwen,
    input  logic [RFIDX_W-1:0] alu_wbck_rdidx,
    input  logic [XLEN-1:0]    alu_wbck_wdat,
    input  logic               longp_wbck_valid,
    output logic               longp_wbck_ready,
    input  logic               longp_wbck_rdwen,
    input  logic [RFIDX_W-1:0] longp_wbck_rdidx,
    input  logic [XLEN-1:0]    longp_wbck_wdat,
    input  logic               longp_issue_valid,
    input  logic [RFIDX_W-1:0] longp_issue_rdidx,
    input  logic [RFIDX_W-1:0] chk_src1_idx,
    input  logic [RFIDX_W-1:0] chk_src2_idx,
    input  logic [RFIDX_W-1:0] chk_dest_idx,
    output logic               chk_src1_hzd,
    output logic               chk_src2_hzd,
    output logic               chk_dest_hzd,
    output logic               rf_wbck_ena,
    output logic [RFIDX_W-1:0] rf_wbck_rdidx,
    output logic [XLEN-1:0]    rf_wbck_wdat
);

    localparam int               CNT_W   = starve_cnt_w(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;
    logic             starve_force;
    logic             alu_hs;
    logic             longp_hs;
    wbck_gnt_e        gnt;

    // Forcing only matters while the ALU still requests, so a dropped request never stalls long-pipe.
    assign starve_force     = alu_wbck_valid & (starve_cnt == CNT_MAX);
    assign longp_wbck_ready = ~starve_force;
    assign alu_wbck_ready   = rst_n & (starve_force | ~longp_wbck_valid);
    assign alu_hs           = alu_wbck_valid & alu_wbck_ready;
    assign longp_hs         = rst_n & longp_wbck_valid & longp_wbck_ready;

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!alu_wbck_valid || alu_hs) begin
            starve_cnt_nxt = '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
    end

    sirv_gnrl_dfflr #(.DW(CNT_W)) u_starve_dff (
        .lden  (1'b1),
        .dnxt  (starve_cnt_nxt),
        .qout  (starve_cnt),
        .clk   (clk),
        .rst_n (rst_n)
    );

    // Writes to x0 and handshake-only results leave the port idle with zeroed index/data.
    always_comb begin
        gnt = GNT_NONE;
        if (longp_hs)    gnt = GNT_LONGP;
        else if (alu_hs) gnt = GNT_ALU;
        rf_wbck_ena   = 1'b0;
        rf_wbck_rdidx = '0;
        rf_wbck_wdat  = '0;
        case (gnt)
            GNT_LONGP: begin
                if (longp_wbck_rdwen && (longp_wbck_rdidx != '0)) begin
                    rf_wbck_ena   = 1'b1;
                    rf_wbck_rdidx = longp_wbck_rdidx;
                    rf_wbck_wdat  = longp_wbck_wdat;
                end
            end
            GNT_ALU: begin
                if (alu_wbck_rdwen && (alu_wbck_rdidx != '0)) begin
                    rf_wbck_ena   = 1'b1;
                    rf_wbck_rdidx = alu_wbck_rdidx;
                    rf_wbck_wdat  = alu_wbck_wdat;
                end
            end
            default: ;
        endcase
    end

`ifdef E203_WBCK_LONGP_SB_EN
    e203_exu_wbck_sb #(
        .RFIDX_W   (RFIDX_W),
        .RFREG_NUM (RFREG_NUM)
    ) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_vld      (longp_issue_valid & (longp_issue_rdidx != '0)),
        .set_idx      (longp_issue_rdidx),
        .clr_vld      (longp_hs & longp_wbck_rdwen),
        .clr_idx      (longp_wbck_rdidx),
        .chk_src1_idx (chk_src1_idx),
        .chk_src2_idx (chk_src2_idx),
        .chk_dest_idx (chk_dest_idx),
        .chk_src1_hzd (chk_src1_hzd),
        .chk_src2_hzd (chk_src2_hzd),
        .chk_dest_hzd (chk_dest_hzd)
    );
`else
    logic unused_sb;
    assign unused_sb    = ^{longp_issue_valid, longp_issue_rdidx,
                            chk_src1_idx, chk_src2_idx, chk_dest_idx};
    assign chk_src1_hzd = 1'b0;
    assign chk_src2_hzd = 1'b0;
    assign chk_dest_hzd = 1'b0;
`endif

endmodule
